// File: rtl/spatz_issue_scoreboard.sv
// -----------------------------------------------------------------------------
// spatz_issue_scoreboard
//
// Single-entry issue stage between the Spatz controller and the execution
// units (0 = VFU, 1 = VLSU, 2 = VSLDU). It holds one request, stalls it while
// it has a RAW/WAW hazard against a pending vector-register write, dispatches
// it to its target unit, and counts in-flight operations per unit. Unit
// completions clear the pending-write bits and decrement the counters.
//
// Handshake semantics (both the request side and the dispatch side):
//   A transfer happens on a rising clk_i edge where valid and ready are both
//   high. A producer that raises valid keeps it high, with stable payload,
//   until the transfer. Ready may depend combinationally on valid; valid never
//   depends on ready. Here unit_valid_o is a function of registered state and
//   of the completion inputs only (no path from req_* to unit_*). req_ready_o
//   is high when the entry is empty or is being dispatched this cycle.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous reset, active-high
//   req_valid_i    request from controller valid
//   req_ready_o    issue stage can accept a request
//   req_unit_i     target unit index (>= NrUnits is dropped and flagged)
//   req_id_i       instruction id
//   req_vd_i       destination vreg,  req_use_vd_i  : request writes vd
//   req_vs1_i      source vreg 1,     req_use_vs1_i : request reads vs1
//   req_vs2_i      source vreg 2,     req_use_vs2_i : request reads vs2
//   unit_valid_o   one-hot dispatch valid
//   unit_ready_i   unit accepts dispatch
//   unit_id_o      id of the held op (0 when empty)
//   done_valid_i   unit completed one op
//   done_vd_i      vd of the completing op, slice u*VRegW +: VRegW per unit
//   done_use_vd_i  completing op had a vd
//   busy_o         entry held, any pending write, or any op in flight
//   err_o          sticky error flag
//
// The FSM state is visible as state_q for debug.
// -----------------------------------------------------------------------------
module spatz_issue_scoreboard #(
    parameter int unsigned NrVRegs        = 32,
    parameter int unsigned NrUnits        = 3,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned IdWidth        = 5,
    localparam int unsigned VRegW         = $clog2(NrVRegs),
    localparam int unsigned UnitW         = (NrUnits > 1) ? $clog2(NrUnits) : 1,
    localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [UnitW-1:0]           req_unit_i,
    input  logic [IdWidth-1:0]         req_id_i,
    input  logic [VRegW-1:0]           req_vd_i,
    input  logic                       req_use_vd_i,
    input  logic [VRegW-1:0]           req_vs1_i,
    input  logic                       req_use_vs1_i,
    input  logic [VRegW-1:0]           req_vs2_i,
    input  logic                       req_use_vs2_i,
    output logic [NrUnits-1:0]         unit_valid_o,
    input  logic [NrUnits-1:0]         unit_ready_i,
    output logic [IdWidth-1:0]         unit_id_o,
    input  logic [NrUnits-1:0]         done_valid_i,
    input  logic [NrUnits*VRegW-1:0]   done_vd_i,
    input  logic [NrUnits-1:0]         done_use_vd_i,
    output logic                       busy_o,
    output logic                       err_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_e;

    typedef struct packed {
        logic [UnitW-1:0]   unit;
        logic [IdWidth-1:0] id;
        logic [VRegW-1:0]   vd;
        logic               use_vd;
        logic [VRegW-1:0]   vs1;
        logic               use_vs1;
        logic [VRegW-1:0]   vs2;
        logic               use_vs2;
    } entry_t;

    state_e              state_q, state_d;
    entry_t              entry_q, entry_d, req_entry;
    logic [NrVRegs-1:0]  sb_q, sb_d;
    logic [NrVRegs-1:0]  clr, sb_eff, set_vec;
    logic [CntW-1:0]     cnt_q [NrUnits];
    logic [CntW-1:0]     cnt_d [NrUnits];
    logic                err_q, err_d;
    logic                hazard;
    logic                fire;
    logic                accept;
    logic                req_legal;

    // ------------------------------------------------------------------
    // Completion decode. Clears are applied to the hazard check in the same
    // cycle, so an op waiting on a register can leave on the completion cycle.
    // ------------------------------------------------------------------
    always_comb begin
        clr = '0;
        for (int u = 0; u < int'(NrUnits); u++) begin
            if (done_valid_i[u] && done_use_vd_i[u]) begin
                clr[done_vd_i[u*VRegW +: VRegW]] = 1'b1;
            end
        end
    end

    assign sb_eff = sb_q & ~clr;

    assign hazard = (entry_q.use_vs1 && sb_eff[entry_q.vs1])
                 || (entry_q.use_vs2 && sb_eff[entry_q.vs2])
                 || (entry_q.use_vd  && sb_eff[entry_q.vd]);

    // ------------------------------------------------------------------
    // Dispatch. Only state and completions feed unit_valid_o. Once high it
    // stays high: while the entry is held nothing can set a new sb bit or
    // raise a counter, so the hazard and the credit check can only relax.
    // ------------------------------------------------------------------
    always_comb begin
        unit_valid_o = '0;
        for (int u = 0; u < int'(NrUnits); u++) begin
            unit_valid_o[u] = (state_q == HELD)
                           && (entry_q.unit == UnitW'(u))
                           && !hazard
                           && (cnt_q[u] < CntW'(MaxOutstanding));
        end
    end

    assign fire        = |(unit_valid_o & unit_ready_i);
    assign req_ready_o = (state_q == EMPTY) || fire;
    assign accept      = req_valid_i && req_ready_o;
    assign req_legal   = int'(req_unit_i) < int'(NrUnits);
    assign unit_id_o   = (state_q == HELD) ? entry_q.id : '0;

    always_comb begin
        req_entry         = '0;
        req_entry.unit    = req_unit_i;
        req_entry.id      = req_id_i;
        req_entry.vd      = req_vd_i;
        req_entry.use_vd  = req_use_vd_i;
        req_entry.vs1     = req_vs1_i;
        req_entry.use_vs1 = req_use_vs1_i;
        req_entry.vs2     = req_vs2_i;
        req_entry.use_vs2 = req_use_vs2_i;
    end

    // ------------------------------------------------------------------
    // Entry FSM. An illegal unit index is consumed by the handshake but
    // never stored.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        case (state_q)
            EMPTY: begin
                if (accept && req_legal) begin
                    state_d = HELD;
                    entry_d = req_entry;
                end
            end
            HELD: begin
                if (fire) begin
                    state_d = EMPTY;
                    if (accept && req_legal) begin
                        state_d = HELD;
                        entry_d = req_entry;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // ------------------------------------------------------------------
    // Scoreboard: a dispatch sets its vd after the clears, so a set and a
    // clear of the same register in one cycle leaves the bit set.
    // ------------------------------------------------------------------
    always_comb begin
        set_vec = '0;
        if (fire && entry_q.use_vd) begin
            set_vec[entry_q.vd] = 1'b1;
        end
        sb_d = sb_eff | set_vec;
    end

    // ------------------------------------------------------------------
    // In-flight counters and error flag.
    // ------------------------------------------------------------------
    always_comb begin
        err_d = err_q;
        if (accept && !req_legal) begin
            err_d = 1'b1;
        end
        for (int u = 0; u < int'(NrUnits); u++) begin
            cnt_d[u] = cnt_q[u];
            if (unit_valid_o[u] && unit_ready_i[u] && !done_valid_i[u]) begin
                cnt_d[u] = cnt_q[u] + CntW'(1);
            end else if (!(unit_valid_o[u] && unit_ready_i[u]) && done_valid_i[u]
                         && (cnt_q[u] != '0)) begin
                cnt_d[u] = cnt_q[u] - CntW'(1);
            end
            if (done_valid_i[u]) begin
                if (cnt_q[u] == '0) begin
                    err_d = 1'b1;
                end
                if (done_use_vd_i[u] && !sb_q[done_vd_i[u*VRegW +: VRegW]]) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy_o = (state_q == HELD) || (|sb_q);
        for (int u = 0; u < int'(NrUnits); u++) begin
            if (cnt_q[u] != '0) begin
                busy_o = 1'b1;
            end
        end
    end

    assign err_o = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            entry_q <= '0;
            sb_q    <= '0;
            err_q   <= 1'b0;
            for (int u = 0; u < int'(NrUnits); u++) begin
                cnt_q[u] <= '0;
            end
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            sb_q    <= sb_d;
            err_q   <= err_d;
            for (int u = 0; u < int'(NrUnits); u++) begin
                cnt_q[u] <= cnt_d[u];
            end
        end
    end

endmodule

// File: tb/tb_spatz_issue_scoreboard.sv
module tb_spatz_issue_scoreboard;

  localparam int NU = 3;
  localparam int VW = 5;
  localparam int IW = 5;
  localparam int MAXO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  logic              req_valid_i, req_ready_o;
  logic [1:0]        req_unit_i;
  logic [IW-1:0]     req_id_i;
  logic [VW-1:0]     req_vd_i, req_vs1_i, req_vs2_i;
  logic              req_use_vd_i, req_use_vs1_i, req_use_vs2_i;
  logic [NU-1:0]     unit_valid_o, unit_ready_i;
  logic [IW-1:0]     unit_id_o;
  logic [NU-1:0]     done_valid_i, done_use_vd_i;
  logic [NU*VW-1:0]  done_vd_i;
  logic              busy_o, err_o;

  spatz_issue_scoreboard dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_unit_i   (req_unit_i),
    .req_id_i     (req_id_i),
    .req_vd_i     (req_vd_i),
    .req_use_vd_i (req_use_vd_i),
    .req_vs1_i    (req_vs1_i),
    .req_use_vs1_i(req_use_vs1_i),
    .req_vs2_i    (req_vs2_i),
    .req_use_vs2_i(req_use_vs2_i),
    .unit_valid_o (unit_valid_o),
    .unit_ready_i (unit_ready_i),
    .unit_id_o    (unit_id_o),
    .done_valid_i (done_valid_i),
    .done_vd_i    (done_vd_i),
    .done_use_vd_i(done_use_vd_i),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit  m_held;
  int  m_unit, m_id, m_vd, m_vs1, m_vs2;
  bit  m_use_vd, m_use1, m_use2;
  bit  m_sb [32];
  int  m_cnt [NU];
  bit  m_err;
  // in-flight ops, oldest first: {unit[1:0], use_vd, vd[4:0]}
  logic [7:0] exp_q[$];

  bit        clrv [32];
  bit [2:0]  e_valid;
  bit        e_ready, e_busy, e_fire;
  int        e_id;

  task automatic eval_comb();
    bit hz;
    for (int r = 0; r < 32; r++) clrv[r] = 0;
    for (int u = 0; u < NU; u++)
      if (done_valid_i[u] && done_use_vd_i[u]) clrv[done_vd_i[u*VW +: VW]] = 1;
    hz = (m_use1 && m_sb[m_vs1] && !clrv[m_vs1])
      || (m_use2 && m_sb[m_vs2] && !clrv[m_vs2])
      || (m_use_vd && m_sb[m_vd] && !clrv[m_vd]);
    e_valid = '0;
    for (int u = 0; u < NU; u++)
      if (m_held && m_unit == u && !hz && m_cnt[u] < MAXO) e_valid[u] = 1;
    e_fire  = |(e_valid & unit_ready_i);
    e_ready = !m_held || e_fire;
    e_id    = m_held ? m_id : 0;
    e_busy  = m_held;
    for (int r = 0; r < 32; r++) if (m_sb[r]) e_busy = 1;
    for (int u = 0; u < NU; u++) if (m_cnt[u] != 0) e_busy = 1;
  endtask

  task automatic model_step();
    bit acc;
    int idx;
    eval_comb();
    if (rst_i) begin
      m_held = 0; m_err = 0;
      m_use_vd = 0; m_use1 = 0; m_use2 = 0;
      for (int r = 0; r < 32; r++) m_sb[r] = 0;
      for (int u = 0; u < NU; u++) m_cnt[u] = 0;
      exp_q.delete();
    end else begin
      acc = req_valid_i && e_ready;
      for (int u = 0; u < NU; u++) begin
        if (done_valid_i[u]) begin
          if (m_cnt[u] == 0) m_err = 1;
          if (done_use_vd_i[u] && !m_sb[done_vd_i[u*VW +: VW]]) m_err = 1;
          idx = -1;
          foreach (exp_q[i]) if (idx < 0 && int'(exp_q[i][7:6]) == u) idx = i;
          if (idx >= 0) exp_q.delete(idx);
        end
      end
      for (int r = 0; r < 32; r++)
        m_sb[r] = (m_sb[r] && !clrv[r]) || (e_fire && m_use_vd && m_vd == r);
      for (int u = 0; u < NU; u++) begin
        if (e_valid[u] && unit_ready_i[u] && !done_valid_i[u]) m_cnt[u]++;
        else if (!(e_valid[u] && unit_ready_i[u]) && done_valid_i[u] && m_cnt[u] > 0) m_cnt[u]--;
      end
      if (e_fire) begin
        exp_q.push_back({m_unit[1:0], m_use_vd, m_vd[4:0]});
        m_held = 0;
      end
      if (acc) begin
        if (req_unit_i >= 2'(NU)) m_err = 1;
        else begin
          m_held = 1; m_unit = int'(req_unit_i); m_id = int'(req_id_i);
          m_vd = int'(req_vd_i); m_use_vd = req_use_vd_i;
          m_vs1 = int'(req_vs1_i); m_use1 = req_use_vs1_i;
          m_vs2 = int'(req_vs2_i); m_use2 = req_use_vs2_i;
        end
      end
    end
  endtask

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      #2;
      eval_comb();
      chk("unit_valid", int'(unit_valid_o), int'(e_valid));
      chk("req_ready",  int'(req_ready_o),  int'(e_ready));
      chk("unit_id",    int'(unit_id_o),    e_id);
      chk("busy",       int'(busy_o),       int'(e_busy));
      chk("err",        int'(err_o),        int'(m_err));
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    rst_i = 0;
    req_valid_i = 0; req_unit_i = '0; req_id_i = '0;
    req_vd_i = '0; req_use_vd_i = 0;
    req_vs1_i = '0; req_use_vs1_i = 0;
    req_vs2_i = '0; req_use_vs2_i = 0;
    unit_ready_i = '1;
    done_valid_i = '0; done_use_vd_i = '0; done_vd_i = '0;
  endtask

  task automatic step();
    @(negedge clk);
    set_idle();
  endtask

  task automatic req(input int unit, input int id, input int vd, input bit uvd,
                     input int vs1, input bit u1, input int vs2, input bit u2);
    req_valid_i = 1; req_unit_i = 2'(unit); req_id_i = IW'(id);
    req_vd_i = VW'(vd); req_use_vd_i = uvd;
    req_vs1_i = VW'(vs1); req_use_vs1_i = u1;
    req_vs2_i = VW'(vs2); req_use_vs2_i = u2;
  endtask

  task automatic done1(input int u, input int vd, input bit use_vd);
    done_valid_i[u] = 1;
    done_use_vd_i[u] = use_vd;
    done_vd_i[u*VW +: VW] = VW'(vd);
  endtask

  task automatic do_reset();
    step(); rst_i = 1;
    step(); rst_i = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_idle();
    rst_i = 1;
    do_reset();

    // reset values
    step(); #2;
    chk("rst_ready", int'(req_ready_o), 1);
    chk("rst_valid", int'(unit_valid_o), 0);
    chk("rst_busy",  int'(busy_o), 0);
    chk("rst_err",   int'(err_o), 0);

    // RAW: VFU writes v3, VLSU reads v3
    req(0, 1, 3, 1, 0, 0, 0, 0);
    step(); req(1, 2, 0, 0, 3, 1, 0, 0); #2;
    chk("raw_vfu_valid", int'(unit_valid_o), 3'b001);
    step(); #2;
    chk("raw_stall_c", int'(unit_valid_o), 0);
    chk("raw_ready_c", int'(req_ready_o), 0);
    step(); #2;
    chk("raw_stall_d", int'(unit_valid_o), 0);
    step(); done1(0, 3, 1); #2;
    chk("raw_bypass", int'(unit_valid_o), 3'b010);
    step(); done1(1, 0, 0);
    step(); #2;
    chk("raw_idle_busy", int'(busy_o), 0);

    // back-to-back VFU, credit limit
    req(0, 10, 8, 1, 0, 0, 0, 0);
    for (int k = 2; k <= 5; k++) begin
      step(); req(0, 10 + k - 1, 8 + k - 1, 1, 0, 0, 0, 0); #2;
      chk("b2b_valid", int'(unit_valid_o), 3'b001);
      chk("b2b_ready", int'(req_ready_o), 1);
    end
    step(); #2;
    chk("cred_stall_valid", int'(unit_valid_o), 0);
    chk("cred_stall_ready", int'(req_ready_o), 0);
    step(); #2;
    chk("cred_stall2", int'(unit_valid_o), 0);
    step(); done1(0, 8, 1); #2;
    chk("cred_done_cycle", int'(unit_valid_o), 0);
    step(); #2;
    chk("cred_go", int'(unit_valid_o), 3'b001);
    chk("cred_go_id", int'(unit_id_o), 14);
    for (int v = 9; v <= 12; v++) begin
      step(); done1(0, v, 1);
    end
    step(); #2;
    chk("b2b_idle_busy", int'(busy_o), 0);

    // set/clear race on v5
    req(0, 3, 5, 1, 0, 0, 0, 0);
    step();
    step(); req(0, 4, 5, 1, 0, 0, 0, 0);
    step(); done1(0, 5, 1); #2;
    chk("race_valid", int'(unit_valid_o), 3'b001);
    step(); #2;
    chk("race_sb5", int'(dut.sb_q[5]), 1);
    done1(0, 5, 1);
    step(); #2;
    chk("race_idle_busy", int'(busy_o), 0);

    // backpressure on VSLDU
    req(2, 7, 2, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(); unit_ready_i = 3'b011; #2;
      chk("bp_valid", int'(unit_valid_o), 3'b100);
      chk("bp_id",    int'(unit_id_o), 7);
      chk("bp_ready", int'(req_ready_o), 0);
    end
    step(); #2;
    chk("bp_release", int'(unit_valid_o), 3'b100);
    chk("bp_release_ready", int'(req_ready_o), 1);
    step(); done1(2, 2, 1);

    // completion with counter at 0
    step(); done1(1, 0, 0);
    step(); #2;
    chk("err_set", int'(err_o), 1);
    step(); #2;
    chk("err_sticky", int'(err_o), 1);

    // reset while an entry is held
    req(0, 9, 1, 1, 0, 0, 0, 0); unit_ready_i = '0;
    step(); unit_ready_i = '0; #2;
    chk("held_busy", int'(busy_o), 1);
    rst_i = 1;
    step(); #2;
    chk("held_rst_busy",  int'(busy_o), 0);
    chk("held_rst_err",   int'(err_o), 0);
    chk("held_rst_valid", int'(unit_valid_o), 0);

    // illegal unit index
    req(3, 6, 4, 1, 0, 0, 0, 0); #2;
    chk("illegal_ready", int'(req_ready_o), 1);
    step(); #2;
    chk("illegal_err",  int'(err_o), 1);
    chk("illegal_busy", int'(busy_o), 0);
    do_reset();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      if ($urandom_range(0, 2) != 0)
        req($urandom_range(0, NU - 1), $urandom_range(0, 31),
            $urandom_range(0, 7), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      unit_ready_i = 3'($urandom_range(0, 7));
      for (int u = 0; u < NU; u++) begin
        int idx;
        idx = -1;
        foreach (exp_q[i]) if (idx < 0 && int'(exp_q[i][7:6]) == u) idx = i;
        if (idx >= 0 && $urandom_range(0, 2) == 0) begin
          if (exp_q[idx][5]) done1(u, int'(exp_q[idx][4:0]), 1);
          else done1(u, $urandom_range(0, 31), 0);
        end
      end
      if ($urandom_range(0, 299) == 0) rst_i = 1;
    end

    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
